// File: rtl/pspin_ingress_tag_enc.sv
// pspin_ingress_tag_enc
// Turns matched-packet descriptors from the allocator into ingress DMA write
// commands. The DMA tag carries {msgid, is_eom, ctx_id} so the HER generator
// can rebuild the handler context on completion. A single output register
// holds the command, and a credit counter bounds the number of commands that
// are buffered or in flight. Credits come back through cpl_valid.
//
// Optional build macro: PSPIN_TAG_ENC_STATS_EN
//   When defined, this adds 32-bit wrapping counters on these ports:
//   stat_cmd_cnt, stat_eom_cnt and stat_drop_cnt.
module pspin_ingress_tag_enc #(
  parameter int C_MSGID_WIDTH   = 10,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH       = 20,
  parameter int TAG_WIDTH       = 32,
  parameter int NUM_HANDLER_CTX = 4,
  parameter int MAX_INFLIGHT    = 16,
  localparam int CTX_ID_WIDTH   = $clog2(NUM_HANDLER_CTX),
  localparam int CNT_WIDTH      = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                      clk,
  input  logic                      rstn,
  // descriptor input from the matching engine / allocator
  input  logic                      match_valid,
  output logic                      match_ready,
  input  logic [C_MSGID_WIDTH-1:0]  match_msgid,
  input  logic                      match_is_eom,
  input  logic [CTX_ID_WIDTH-1:0]   match_ctx_id,
  input  logic [AXI_ADDR_WIDTH-1:0] match_addr,
  input  logic [LEN_WIDTH-1:0]      match_len,
  // ingress DMA command port
  output logic                      dma_valid,
  input  logic                      dma_ready,
  output logic [AXI_ADDR_WIDTH-1:0] dma_addr,
  output logic [LEN_WIDTH-1:0]      dma_len,
  output logic [TAG_WIDTH-1:0]      dma_tag,
  // credit return and status
  input  logic                      cpl_valid,
  output logic [CNT_WIDTH-1:0]      outstanding,
`ifdef PSPIN_TAG_ENC_STATS_EN
  output logic [31:0]               stat_cmd_cnt,
  output logic [31:0]               stat_eom_cnt,
  output logic [31:0]               stat_drop_cnt,
`endif
  output logic                      idle,
  output logic                      err_underflow
);

  // Tag layout: ctx_id in the LSBs, is_eom above it, then msgid.
  // Any remaining upper bits are zero.
  localparam int FIELD_W = C_MSGID_WIDTH + 1 + CTX_ID_WIDTH;
  localparam int EOM_BIT = CTX_ID_WIDTH;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_INFLIGHT);

  // Reject configurations that cannot hold the tag or have no credits.
  generate
    if (TAG_WIDTH < FIELD_W) begin : g_bad_tag_width
      $error("pspin_ingress_tag_enc: TAG_WIDTH too small for msgid+eom+ctx_id");
    end
    if (MAX_INFLIGHT < 1) begin : g_bad_inflight
      $error("pspin_ingress_tag_enc: MAX_INFLIGHT must be at least 1");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                      dma_valid_q, dma_valid_d;
  logic [AXI_ADDR_WIDTH-1:0] dma_addr_q,  dma_addr_d;
  logic [LEN_WIDTH-1:0]      dma_len_q,   dma_len_d;
  logic [TAG_WIDTH-1:0]      dma_tag_q,   dma_tag_d;
  logic [CNT_WIDTH-1:0]      outstanding_q, outstanding_d;
  logic                      err_underflow_q, err_underflow_d;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic out_free;       // output register can take a new command this cycle
  logic credit_avail;   // fewer than MAX_INFLIGHT commands outstanding
  logic accept;         // descriptor consumed this cycle
  logic load;           // accepted descriptor becomes a DMA command
  logic drop;           // accepted zero-length descriptor, discarded
  logic dma_fire;       // DMA command handshake this cycle
  logic cpl_ok;         // completion that returns a credit
  logic cpl_bad;        // completion with no credit outstanding

  assign out_free     = !dma_valid_q || dma_ready;
  assign credit_avail = (outstanding_q < CNT_MAX);
  assign match_ready  = out_free && credit_avail;
  assign accept       = match_valid && match_ready;
  assign load         = accept && (match_len != '0);
  assign drop         = accept && (match_len == '0);
  assign dma_fire     = dma_valid_q && dma_ready;
  assign cpl_ok       = cpl_valid && (outstanding_q != '0);
  assign cpl_bad      = cpl_valid && (outstanding_q == '0);

  // ---------------------------------------------------------------------------
  // Tag assembly: place each field bit LSB-aligned and zero-fill the rest.
  // ---------------------------------------------------------------------------
  logic [FIELD_W-1:0]   tag_fields;
  logic [TAG_WIDTH-1:0] tag_new;

  assign tag_fields = {match_msgid, match_is_eom, match_ctx_id};

  generate
    for (genvar gi = 0; gi < TAG_WIDTH; gi++) begin : g_tag_bit
      if (gi < FIELD_W) begin : g_field
        assign tag_new[gi] = tag_fields[gi];
      end else begin : g_zero
        assign tag_new[gi] = 1'b0;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------

  // Output command register: load on a non-empty accept, otherwise hold until taken.
  always_comb begin
    dma_valid_d = dma_valid_q;
    dma_addr_d  = dma_addr_q;
    dma_len_d   = dma_len_q;
    dma_tag_d   = dma_tag_q;
    if (load) begin
      dma_valid_d = 1'b1;
      dma_addr_d  = match_addr;
      dma_len_d   = match_len;
      dma_tag_d   = tag_new;
    end else if (dma_fire) begin
      dma_valid_d = 1'b0;
    end
  end

  // Credit counter: +1 per issued command, -1 per completion, net zero when both happen.
  always_comb begin
    outstanding_d = outstanding_q;
    unique case ({load, cpl_ok})
      2'b10:   outstanding_d = outstanding_q + CNT_WIDTH'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_WIDTH'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Sticky underflow flag. A stray completion is ignored by the counter.
  always_comb begin
    err_underflow_d = err_underflow_q | cpl_bad;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // Command register and credit state. Reset drops any pending command and clears all credits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dma_valid_q     <= 1'b0;
      dma_addr_q      <= '0;
      dma_len_q       <= '0;
      dma_tag_q       <= '0;
      outstanding_q   <= '0;
      err_underflow_q <= 1'b0;
    end else begin
      dma_valid_q     <= dma_valid_d;
      dma_addr_q      <= dma_addr_d;
      dma_len_q       <= dma_len_d;
      dma_tag_q       <= dma_tag_d;
      outstanding_q   <= outstanding_d;
      err_underflow_q <= err_underflow_d;
    end
  end

`ifdef PSPIN_TAG_ENC_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics: free-running wrapping counters
  // ---------------------------------------------------------------------------
  logic [31:0] stat_cmd_cnt_q,  stat_cmd_cnt_d;
  logic [31:0] stat_eom_cnt_q,  stat_eom_cnt_d;
  logic [31:0] stat_drop_cnt_q, stat_drop_cnt_d;

  // Count DMA handshakes, end-of-message handshakes and zero-length drops.
  always_comb begin
    stat_cmd_cnt_d  = stat_cmd_cnt_q;
    stat_eom_cnt_d  = stat_eom_cnt_q;
    stat_drop_cnt_d = stat_drop_cnt_q;
    if (dma_fire) begin
      stat_cmd_cnt_d = stat_cmd_cnt_q + 32'd1;
      if (dma_tag_q[EOM_BIT]) begin
        stat_eom_cnt_d = stat_eom_cnt_q + 32'd1;
      end
    end
    if (drop) begin
      stat_drop_cnt_d = stat_drop_cnt_q + 32'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_cmd_cnt_q  <= '0;
      stat_eom_cnt_q  <= '0;
      stat_drop_cnt_q <= '0;
    end else begin
      stat_cmd_cnt_q  <= stat_cmd_cnt_d;
      stat_eom_cnt_q  <= stat_eom_cnt_d;
      stat_drop_cnt_q <= stat_drop_cnt_d;
    end
  end

  assign stat_cmd_cnt  = stat_cmd_cnt_q;
  assign stat_eom_cnt  = stat_eom_cnt_q;
  assign stat_drop_cnt = stat_drop_cnt_q;
`else
  // The drop strobe only feeds the statistics counters.
  logic unused_drop;
  assign unused_drop = drop;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dma_valid     = dma_valid_q;
  assign dma_addr      = dma_addr_q;
  assign dma_len       = dma_len_q;
  assign dma_tag       = dma_tag_q;
  assign outstanding   = outstanding_q;
  assign err_underflow = err_underflow_q;
  assign idle          = (outstanding_q == '0) && !dma_valid_q;

endmodule

// File: tb/tb_pspin_ingress_tag_enc.sv
// Testbench for pspin_ingress_tag_enc (default parameters).
// It runs a table of single descriptors, then hand-written sequences for
// backpressure, credit exhaustion, simultaneous accept and completion,
// zero-length drop, underflow and reset during a transfer.
// The optional PSPIN_TAG_ENC_STATS_EN counters are checked when defined.
module tb_pspin_ingress_tag_enc;

  logic        clk;
  logic        rstn;
  logic        match_valid;
  logic        match_ready;
  logic [9:0]  match_msgid;
  logic        match_is_eom;
  logic [1:0]  match_ctx_id;
  logic [31:0] match_addr;
  logic [19:0] match_len;
  logic        dma_valid;
  logic        dma_ready;
  logic [31:0] dma_addr;
  logic [19:0] dma_len;
  logic [31:0] dma_tag;
  logic        cpl_valid;
  logic [4:0]  outstanding;
  logic        idle;
  logic        err_underflow;
`ifdef PSPIN_TAG_ENC_STATS_EN
  logic [31:0] stat_cmd_cnt;
  logic [31:0] stat_eom_cnt;
  logic [31:0] stat_drop_cnt;
`endif

  int cmp_cnt = 0;
  int err_cnt = 0;

  pspin_ingress_tag_enc dut (
    .clk          (clk),
    .rstn         (rstn),
    .match_valid  (match_valid),
    .match_ready  (match_ready),
    .match_msgid  (match_msgid),
    .match_is_eom (match_is_eom),
    .match_ctx_id (match_ctx_id),
    .match_addr   (match_addr),
    .match_len    (match_len),
    .dma_valid    (dma_valid),
    .dma_ready    (dma_ready),
    .dma_addr     (dma_addr),
    .dma_len      (dma_len),
    .dma_tag      (dma_tag),
    .cpl_valid    (cpl_valid),
    .outstanding  (outstanding),
`ifdef PSPIN_TAG_ENC_STATS_EN
    .stat_cmd_cnt (stat_cmd_cnt),
    .stat_eom_cnt (stat_eom_cnt),
    .stat_drop_cnt(stat_drop_cnt),
`endif
    .idle         (idle),
    .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  msgid;
    logic        eom;
    logic [1:0]  ctx;
    logic [31:0] addr;
    logic [19:0] len;
    logic        exp_valid;
    logic [31:0] exp_tag;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input logic [9:0] msgid, input logic eom, input logic [1:0] ctx,
                          input logic [31:0] addr, input logic [19:0] len);
    match_msgid  = msgid;
    match_is_eom = eom;
    match_ctx_id = ctx;
    match_addr   = addr;
    match_len    = len;
  endtask

  // Pulse cpl_valid for n consecutive cycles.
  task automatic return_credits(input int n);
    cpl_valid = 1'b1;
    for (int k = 0; k < n; k++) step();
    cpl_valid = 1'b0;
  endtask

`ifdef PSPIN_TAG_ENC_STATS_EN
  logic [31:0] cmd0, eom0, drop0;
`endif

  initial begin
    // Tag = {msgid, eom, ctx} LSB-aligned, computed by hand.
    vecs[0] = '{10'h155, 1'b1, 2'd2, 32'h1000_0040, 20'd64,    1'b1, 32'h0000_0AAE};
    vecs[1] = '{10'h3FF, 1'b0, 2'd3, 32'hFFFF_FFFC, 20'hFFFFF, 1'b1, 32'h0000_1FFB};
    vecs[2] = '{10'h001, 1'b1, 2'd0, 32'h0000_0000, 20'd1,     1'b1, 32'h0000_000C};
    vecs[3] = '{10'h2A5, 1'b0, 2'd1, 32'h8000_0000, 20'd128,   1'b1, 32'h0000_1529};
    vecs[4] = '{10'h000, 1'b0, 2'd0, 32'h0000_0000, 20'd0,     1'b0, 32'h0000_0000};
    vecs[5] = '{10'h200, 1'b1, 2'd3, 32'h1234_5678, 20'h80000, 1'b1, 32'h0000_1007};

    rstn = 1'b0;
    match_valid = 1'b0;
    dma_ready = 1'b0;
    cpl_valid = 1'b0;
    set_desc(10'h0, 1'b0, 2'd0, 32'h0, 20'h0);
    #12;
    rstn = 1'b1;
    step();

    // ---- reset state ----
    $display("reset state check");
    chk("rst_dma_valid",   64'(dma_valid), 64'd0);
    chk("rst_dma_addr",    64'(dma_addr), 64'd0);
    chk("rst_dma_len",     64'(dma_len), 64'd0);
    chk("rst_dma_tag",     64'(dma_tag), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_err",         64'(err_underflow), 64'd0);
    chk("rst_idle",        64'(idle), 64'd1);
    chk("rst_match_ready", 64'(match_ready), 64'd1);

    // ---- table-driven single descriptors ----
    dma_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_desc(vecs[i].msgid, vecs[i].eom, vecs[i].ctx, vecs[i].addr, vecs[i].len);
      match_valid = 1'b1;
      #1;
      chk("vec_match_ready", 64'(match_ready), 64'd1);
      step();
      match_valid = 1'b0;
      $display("vec %0d: msgid=0x%0h eom=%0d ctx=%0d len=%0d -> dma_valid=%0d tag=0x%0h",
               i, vecs[i].msgid, vecs[i].eom, vecs[i].ctx, vecs[i].len, dma_valid, dma_tag);
      chk("vec_dma_valid", 64'(dma_valid), 64'(vecs[i].exp_valid));
      chk("vec_outstanding", 64'(outstanding), vecs[i].exp_valid ? 64'd1 : 64'd0);
      if (vecs[i].exp_valid) begin
        chk("vec_dma_tag",  64'(dma_tag), 64'(vecs[i].exp_tag));
        chk("vec_dma_addr", 64'(dma_addr), 64'(vecs[i].addr));
        chk("vec_dma_len",  64'(dma_len), 64'(vecs[i].len));
        chk("vec_busy",     64'(idle), 64'd0);
        return_credits(1);
      end
      chk("vec_cpl_outstanding", 64'(outstanding), 64'd0);
      chk("vec_cpl_idle",        64'(idle), 64'd1);
      chk("vec_cpl_valid_clear", 64'(dma_valid), 64'd0);
    end

    // ---- backpressure: two descriptors with dma_ready low ----
    $display("backpressure sequence");
    dma_ready = 1'b0;
    set_desc(10'h011, 1'b0, 2'd1, 32'hA000_0000, 20'd10);
    match_valid = 1'b1;
    step();
    set_desc(10'h022, 1'b1, 2'd2, 32'hB000_0000, 20'd20);
    #1;
    chk("bp_match_ready_low", 64'(match_ready), 64'd0);
    chk("bp_first_addr", 64'(dma_addr), 64'hA000_0000);
    step();
    chk("bp_hold_valid", 64'(dma_valid), 64'd1);
    chk("bp_hold_addr",  64'(dma_addr), 64'hA000_0000);
    chk("bp_hold_len",   64'(dma_len), 64'd10);
    chk("bp_hold_tag",   64'(dma_tag), 64'h89);
    chk("bp_hold_outst", 64'(outstanding), 64'd1);
    dma_ready = 1'b1;
    #1;
    chk("bp_ready_comb", 64'(match_ready), 64'd1);
    step();
    match_valid = 1'b0;
    chk("bp_second_valid", 64'(dma_valid), 64'd1);
    chk("bp_second_addr",  64'(dma_addr), 64'hB000_0000);
    chk("bp_second_tag",   64'(dma_tag), 64'h116);
    chk("bp_second_outst", 64'(outstanding), 64'd2);
    step();
    chk("bp_drained", 64'(dma_valid), 64'd0);
    return_credits(2);
    chk("bp_outst_zero", 64'(outstanding), 64'd0);

    // ---- credit exhaustion ----
    $display("credit exhaustion sequence");
    set_desc(10'h050, 1'b0, 2'd0, 32'hC000_0000, 20'd4);
    match_valid = 1'b1;
    for (int i = 0; i < 16; i++) step();
    chk("full_outstanding", 64'(outstanding), 64'd16);
    chk("full_match_ready", 64'(match_ready), 64'd0);
    step();
    chk("full_still_16", 64'(outstanding), 64'd16);
    chk("full_no_issue", 64'(dma_valid), 64'd0);
    return_credits(1);
    chk("full_after_cpl", 64'(outstanding), 64'd15);
    chk("full_ready_back", 64'(match_ready), 64'd1);
    step();
    match_valid = 1'b0;
    chk("full_17th_valid", 64'(dma_valid), 64'd1);
    chk("full_17th_outst", 64'(outstanding), 64'd16);
    step();
    return_credits(11);
    chk("to_five", 64'(outstanding), 64'd5);

    // ---- simultaneous accept and completion ----
    $display("simultaneous accept + completion at outstanding=5");
    match_valid = 1'b1;
    cpl_valid = 1'b1;
    step();
    match_valid = 1'b0;
    cpl_valid = 1'b0;
    chk("simul_outstanding", 64'(outstanding), 64'd5);
    chk("simul_dma_valid",   64'(dma_valid), 64'd1);
    return_credits(5);
    chk("simul_drain_outst", 64'(outstanding), 64'd0);
    chk("simul_drain_idle",  64'(idle), 64'd1);

    // ---- zero-length drop then len=128 ----
    $display("zero-length drop sequence");
`ifdef PSPIN_TAG_ENC_STATS_EN
    cmd0 = stat_cmd_cnt;
    eom0 = stat_eom_cnt;
    drop0 = stat_drop_cnt;
`endif
    set_desc(10'h033, 1'b0, 2'd1, 32'hD000_0000, 20'd0);
    match_valid = 1'b1;
    step();
    chk("zl_no_cmd",   64'(dma_valid), 64'd0);
    chk("zl_no_credit", 64'(outstanding), 64'd0);
    set_desc(10'h034, 1'b1, 2'd1, 32'hD000_0100, 20'd128);
    step();
    match_valid = 1'b0;
    chk("zl_cmd_valid", 64'(dma_valid), 64'd1);
    chk("zl_cmd_len",   64'(dma_len), 64'd128);
    chk("zl_cmd_outst", 64'(outstanding), 64'd1);
    step();
    chk("zl_handshake", 64'(dma_valid), 64'd0);
`ifdef PSPIN_TAG_ENC_STATS_EN
    chk("stat_drop_delta", 64'(stat_drop_cnt - drop0), 64'd1);
    chk("stat_cmd_delta",  64'(stat_cmd_cnt - cmd0), 64'd1);
    chk("stat_eom_delta",  64'(stat_eom_cnt - eom0), 64'd1);
`endif
    return_credits(1);
    chk("zl_outst_zero", 64'(outstanding), 64'd0);

    // ---- underflow ----
    $display("underflow sequence");
    chk("uf_err_before", 64'(err_underflow), 64'd0);
    return_credits(1);
    chk("uf_err_set", 64'(err_underflow), 64'd1);
    chk("uf_outst_0", 64'(outstanding), 64'd0);
    step();
    chk("uf_err_sticky", 64'(err_underflow), 64'd1);

    // ---- reset during backpressure ----
    $display("reset during backpressure sequence");
    dma_ready = 1'b0;
    set_desc(10'h0AB, 1'b1, 2'd3, 32'hE000_0000, 20'd256);
    match_valid = 1'b1;
    step();
    match_valid = 1'b0;
    chk("rb_pending", 64'(dma_valid), 64'd1);
    rstn = 1'b0;
    #1;
    chk("rb_valid_drop", 64'(dma_valid), 64'd0);
    chk("rb_err_clear",  64'(err_underflow), 64'd0);
    chk("rb_outst_clear", 64'(outstanding), 64'd0);
    step();
    step();
    rstn = 1'b1;
    dma_ready = 1'b1;
    step();
    return_credits(1);
    chk("rb_late_cpl_err", 64'(err_underflow), 64'd1);
    chk("rb_late_cpl_outst", 64'(outstanding), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
